ctrl_equ: RTL and testbench

//  Sequencer for the MMSE equalizer datapath. Stores received symbols into the per-symbol RX RAMs.

---
 rtl/ctrl_equ.sv | 153 +++++++++++++++
 tb/tb_ctrl_equ.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_equ.sv
// Sequencer for the MMSE equalizer: stores RX symbols, steps the dividers over 12 subcarriers per
// data symbol (pilot skipped), then drains the output RAM into the serial-to-parallel buffer.
module ctrl_equ #(
    parameter int N_SC      = 12,
    parameter int ADDR_W    = 4,
    parameter int PILOT_IDX = 4,
    parameter int DRAIN_CYC = 13
) (
    input  logic              i_clk_equ,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [2:0]        i_rx_sym,
    input  logic              i_est_done,
    input  logic              i_done_div,
    input  logic              i_done_equ,
    output logic [2:0]        o_symbol_num,
    output logic [ADDR_W-1:0] o_wr_add,
    output logic [2:0]        o_state_num,
    output logic [ADDR_W-1:0] o_rd_add,
    output logic [ADDR_W-1:0] o_rd_add_out,
    output logic              o_start_div,
    output logic              o_rst_ser_par,
    output logic              o_busy,
    output logic              o_slot_done,
    output logic              o_ovf
);

    localparam logic [ADDR_W-1:0] LAST_SC    = ADDR_W'(N_SC - 1);
    localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(DRAIN_CYC - 1);
    localparam logic [2:0]        PILOT      = 3'(PILOT_IDX);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sym_num_q, sym_num_d;
    logic [ADDR_W-1:0] wr_add_q, wr_add_d;
    logic [2:0]        state_num_q, state_num_d;
    logic [ADDR_W-1:0] rd_add_q, rd_add_d;
    logic [ADDR_W-1:0] rd_add_out_q, rd_add_out_d;
    logic              slot_done_q, slot_done_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        mask_q, mask_d;
    logic [7:0]        set_mask, clr_mask;

    // Data symbols are 1..7 with the pilot index skipped; 7 wraps to 1.
    function automatic logic [2:0] next_sym(input logic [2:0] s);
        logic [2:0] n;
        n = s + 3'd1;
        if (n == PILOT) n = n + 3'd1;
        if (s == 3'd7)  n = 3'd1;
        return n;
    endfunction

    always_comb begin
        sym_num_d = sym_num_q;
        wr_add_d  = wr_add_q;
        ovf_d     = ovf_q;
        set_mask  = '0;
        if (sym_num_q != 3'd0) begin
            if (wr_add_q == LAST_SC) begin
                sym_num_d          = 3'd0;
                wr_add_d           = '0;
                set_mask[sym_num_q] = 1'b1;
            end else begin
                wr_add_d = wr_add_q + ADDR_W'(1);
            end
        end else if (i_rx_valid && i_rx_sym != 3'd0 && i_rx_sym != PILOT) begin
            if (mask_q[i_rx_sym]) ovf_d = 1'b1;
            else                  sym_num_d = i_rx_sym;
        end
    end

    always_comb begin
        state_d      = state_q;
        state_num_d  = state_num_q;
        rd_add_d     = rd_add_q;
        rd_add_out_d = rd_add_out_q;
        slot_done_d  = 1'b0;
        clr_mask     = '0;
        case (state_q)
            S_IDLE: begin
                if (i_est_done && mask_q[state_num_q]) begin
                    state_d  = S_LOAD;
                    rd_add_d = '0;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (i_done_div) begin
                    if (rd_add_q == LAST_SC) begin
                        rd_add_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        rd_add_d = rd_add_q + ADDR_W'(1);
                        state_d  = S_START;
                    end
                end
            end
            S_DRAIN: begin
                if (i_done_equ || rd_add_out_q == LAST_DRAIN) begin
                    rd_add_out_d          = '0;
                    clr_mask[state_num_q] = 1'b1;
                    state_num_d           = next_sym(state_num_q);
                    slot_done_d           = (state_num_q == 3'd7);
                    state_d               = S_IDLE;
                end else begin
                    rd_add_out_d = rd_add_out_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit 0 never names a symbol; keep it clear so IDLE can index the mask directly.
    assign mask_d = (mask_q | set_mask) & ~clr_mask & 8'hFE;

    always_ff @(posedge i_clk_equ or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            sym_num_q    <= 3'd0;
            wr_add_q     <= '0;
            state_num_q  <= 3'd1;
            rd_add_q     <= '0;
            rd_add_out_q <= '0;
            slot_done_q  <= 1'b0;
            ovf_q        <= 1'b0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            sym_num_q    <= sym_num_d;
            wr_add_q     <= wr_add_d;
            state_num_q  <= state_num_d;
            rd_add_q     <= rd_add_d;
            rd_add_out_q <= rd_add_out_d;
            slot_done_q  <= slot_done_d;
            ovf_q        <= ovf_d;
            mask_q       <= mask_d;
        end
    end

    assign o_symbol_num  = sym_num_q;
    assign o_wr_add      = wr_add_q;
    assign o_state_num   = state_num_q;
    assign o_rd_add      = rd_add_q;
    assign o_rd_add_out  = rd_add_out_q;
    assign o_start_div   = (state_q == S_START);
    assign o_rst_ser_par = (state_q != S_LOAD);
    assign o_busy        = (state_q != S_IDLE);
    assign o_slot_done   = slot_done_q;
    assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_ctrl_equ.sv
// Bench for ctrl_equ: vector table for write-side cases, hand sequences for reset, drain and
// overlap timing, then randomized slots checked against a transaction-level reference model.
module tb_ctrl_equ;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_rx_valid, i_est_done, i_done_div, i_done_equ;
    logic [2:0] i_rx_sym;
    logic [2:0] o_symbol_num, o_state_num;
    logic [3:0] o_wr_add, o_rd_add, o_rd_add_out;
    logic       o_start_div, o_rst_ser_par, o_busy, o_slot_done, o_ovf;

    always #5 clk = ~clk;

    ctrl_equ dut (
        .i_clk_equ(clk), .i_rst(rst), .i_rx_valid(i_rx_valid), .i_rx_sym(i_rx_sym),
        .i_est_done(i_est_done), .i_done_div(i_done_div), .i_done_equ(i_done_equ),
        .o_symbol_num(o_symbol_num), .o_wr_add(o_wr_add), .o_state_num(o_state_num),
        .o_rd_add(o_rd_add), .o_rd_add_out(o_rd_add_out), .o_start_div(o_start_div),
        .o_rst_ser_par(o_rst_ser_par), .o_busy(o_busy), .o_slot_done(o_slot_done), .o_ovf(o_ovf)
    );

    typedef struct {
        logic [2:0] sym;
        logic [2:0] exp_num;
        logic       exp_ovf;
    } wvec_t;
    wvec_t wtab[7];

    int n_vec = 0, n_bad = 0, cyc = 0;
    int order[6] = '{1, 2, 3, 5, 6, 7};

    // reference model state
    int         m_acc;
    logic [2:0] m_wsym;
    logic       m_ovf;
    logic [7:0] m_stored;
    int         m_cur_idx, m_sc, m_slots;
    int         slot_cnt, prev_start_cyc;
    logic       prev_sd;
    bit         chk_gap = 0;
    bit         pv = 0;
    logic [2:0] psym;

    int resp_cnt = 0, resp_delay = 3;
    bit resp_rand = 0;

    // divider model: done pulse resp_delay cycles after each start pulse
    initial begin
        i_done_div = 1'b0;
        forever begin
            @(negedge clk);
            i_done_div = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) i_done_div = 1'b1;
            end
            if (o_start_div && !rst)
                resp_cnt = resp_rand ? int'($urandom_range(1, 4)) : resp_delay;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: expected event did not occur within bound (cycle %0d)", nm, cyc);
    endtask

    task automatic model_reset();
        m_acc = -100; m_wsym = 3'd0; m_ovf = 1'b0; m_stored = '0;
        m_cur_idx = 0; m_sc = 0; m_slots = 0; slot_cnt = 0; prev_sd = 1'b0; pv = 0;
    endtask

    task automatic pulse(input logic [2:0] s);
        i_rx_valid = 1'b1;
        i_rx_sym   = s;
        pv         = 1;
        psym       = s;
    endtask

    // One clock: fold last cycle's stimulus into the model, then compare outputs.
    task automatic step();
        int p;
        logic [2:0] es;
        logic [3:0] ea;
        @(negedge clk);
        cyc++;
        if (pv) begin
            p = cyc - 1;
            if (psym != 3'd0 && psym != 3'd4 && p - m_acc > 12) begin
                if (m_stored[psym]) m_ovf = 1'b1;
                else begin
                    m_acc = p; m_wsym = psym; m_stored[psym] = 1'b1;
                end
            end
        end
        pv = 0;
        i_rx_valid = 1'b0;
        if (cyc - m_acc >= 1 && cyc - m_acc <= 12) begin
            es = m_wsym; ea = 4'(cyc - m_acc - 1);
        end else begin
            es = 3'd0; ea = 4'd0;
        end
        chk("symbol_num", o_symbol_num, es);
        chk("wr_add", o_wr_add, ea);
        chk("ovf", o_ovf, m_ovf);
        if (o_start_div) begin
            chk("eq_state_num", o_state_num, order[m_cur_idx]);
            chk("eq_rd_add", o_rd_add, m_sc);
            if (chk_gap && m_sc != 0) chk("start_gap", cyc - prev_start_cyc, 4);
            prev_start_cyc = cyc;
            m_sc++;
            if (m_sc == 12) begin
                m_sc = 0;
                m_stored[order[m_cur_idx]] = 1'b0;
                m_cur_idx++;
                if (m_cur_idx == 6) begin m_cur_idx = 0; m_slots++; end
            end
        end
        if (o_slot_done) begin
            chk("slot_done_width", prev_sd, 0);
            slot_cnt++;
        end
        prev_sd = o_slot_done;
    endtask

    // Called right after the 12th start pulse of a symbol, divider delay 3.
    task automatic eq_tail(input int nxt, input logic restart);
        repeat (3) step();
        for (int j = 0; j < 13; j++) begin
            step();
            chk("drain_add", o_rd_add_out, j);
            chk("drain_busy", o_busy, 1);
            chk("drain_rd_add", o_rd_add, 0);
        end
        step();
        chk("idle_busy", o_busy, 0);
        chk("next_state_num", o_state_num, nxt);
        chk("drain_clr", o_rd_add_out, 0);
        step();
        chk("restart_busy", o_busy, restart);
        if (restart) chk("restart_load", o_rst_ser_par, 0);
    endtask

    task automatic wait_sym_done(input int idx_before, input string nm);
        for (int k = 0; k < 400 && m_cur_idx == idx_before; k++) step();
        if (m_cur_idx == idx_before) timeout(nm);
    endtask

    task automatic do_reset();
        @(negedge clk); cyc++;
        rst = 1'b1; i_rx_valid = 1'b0; pv = 0;
        @(negedge clk); cyc++;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit found;
        int g;
        wtab[0] = '{3'd4, 3'd0, 1'b0};
        wtab[1] = '{3'd0, 3'd0, 1'b0};
        wtab[2] = '{3'd2, 3'd2, 1'b0};
        wtab[3] = '{3'd2, 3'd0, 1'b1};
        wtab[4] = '{3'd4, 3'd0, 1'b1};
        wtab[5] = '{3'd1, 3'd1, 1'b1};
        wtab[6] = '{3'd5, 3'd5, 1'b1};

        rst = 1'b1; i_rx_valid = 1'b0; i_rx_sym = 3'd0; i_est_done = 1'b0; i_done_equ = 1'b0;
        model_reset();
        #3;
        chk("rst_symbol_num", o_symbol_num, 0);
        chk("rst_wr_add", o_wr_add, 0);
        chk("rst_state_num", o_state_num, 1);
        chk("rst_rd_add", o_rd_add, 0);
        chk("rst_rd_add_out", o_rd_add_out, 0);
        chk("rst_start_div", o_start_div, 0);
        chk("rst_ser_par", o_rst_ser_par, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_slot_done", o_slot_done, 0);
        chk("rst_ovf", o_ovf, 0);
        @(negedge clk); cyc++;
        rst = 1'b0;

        // write-side vectors with the estimate held off
        for (int i = 0; i < 7; i++) begin
            step();
            pulse(wtab[i].sym);
            step();
            chk("tab_symbol_num", o_symbol_num, wtab[i].exp_num);
            chk("tab_ovf", o_ovf, wtab[i].exp_ovf);
            chk("tab_busy", o_busy, 0);
            repeat (12) step();
        end

        // estimate gating
        repeat (5) begin step(); chk("gate_busy", o_busy, 0); end
        i_est_done = 1'b1;
        step();
        chk("gate_load_busy", o_busy, 1);
        chk("gate_load_ser_par", o_rst_ser_par, 0);
        chk("gate_load_state_num", o_state_num, 1);
        chk("gate_load_rd_add", o_rd_add, 0);

        // asynchronous reset in WAIT at subcarrier 5
        resp_delay = 2;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            found = o_busy && !o_start_div && o_rst_ser_par && o_rd_add == 4'd5;
        end
        if (!found) timeout("reach_wait5");
        #1 rst = 1'b1;
        #1;
        chk("arst_symbol_num", o_symbol_num, 0);
        chk("arst_state_num", o_state_num, 1);
        chk("arst_rd_add", o_rd_add, 0);
        chk("arst_rd_add_out", o_rd_add_out, 0);
        chk("arst_ser_par", o_rst_ser_par, 1);
        chk("arst_busy", o_busy, 0);
        chk("arst_ovf", o_ovf, 0);
        @(negedge clk); cyc++;
        rst = 1'b0;
        model_reset();
        repeat (20) begin step(); chk("arst_mask_clear", o_busy, 0); end

        // single symbol, divider done 3 cycles after each start
        resp_delay = 3;
        chk_gap = 1;
        step();
        pulse(3'd1);
        wait_sym_done(0, "sym1_done");
        eq_tail(2, 1'b0);

        // symbol 3 written while symbol 2 is in WAIT
        step();
        pulse(3'd2);
        for (int k = 0; k < 200 && m_sc == 0; k++) step();
        if (m_sc == 0) timeout("sym2_first_start");
        step();
        pulse(3'd3);
        wait_sym_done(1, "sym2_done");
        eq_tail(3, 1'b1);
        wait_sym_done(2, "sym3_done");
        eq_tail(5, 1'b0);

        // early drain exit on done_equ
        step();
        pulse(3'd5);
        wait_sym_done(3, "sym5_done");
        repeat (8) step();
        chk("early_drain_add", o_rd_add_out, 4);
        i_done_equ = 1'b1;
        step();
        i_done_equ = 1'b0;
        chk("early_exit_busy", o_busy, 0);
        chk("early_exit_state_num", o_state_num, 6);
        chk("early_exit_rd_add_out", o_rd_add_out, 0);

        // randomized full slots
        chk_gap = 0;
        resp_rand = 1;
        do_reset();
        for (int slot = 0; slot < 2; slot++) begin
            if (slot == 1) begin
                for (int k = 0; k < 3000 && slot_cnt < 1; k++) step();
                if (slot_cnt < 1) timeout("first_slot_done");
            end
            for (int i = 0; i < 6; i++) begin
                g = $urandom_range(0, 15);
                repeat (g) begin
                    step();
                    if ($urandom_range(0, 7) == 0) pulse(($urandom_range(0, 1) == 1) ? 3'd4 : 3'd0);
                end
                step();
                pulse(3'(order[i]));
                for (int k = 0; k < 13; k++) begin
                    step();
                    if (k < 11 && $urandom_range(0, 3) == 0) pulse(3'($urandom_range(1, 7)));
                end
            end
        end
        for (int k = 0; k < 5000 && m_slots < 2; k++) step();
        if (m_slots < 2) timeout("random_slots");
        repeat (20) step();
        chk("slot_done_count", slot_cnt, m_slots);
        chk("final_busy", o_busy, 0);
        chk("final_state_num", o_state_num, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
